// File: rtl/bi_shift_ctrl.sv
// Bidirectional serial shift sequencer: parallel word in, WIDTH prescaled shift ticks, captured word out.
// Optional BI_SHIFT_PARITY_EN adds a trailing even-parity tick and a received-parity error flag.
module bi_shift_ctrl #(
    parameter int WIDTH = 4,
    parameter int DIVW  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             dir,
    input  logic [DIVW-1:0]  div,
    input  logic             abort,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             shift_en,
    output logic             busy,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             rx_perr
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;
    logic [DIVW-1:0]  presc_q, presc_d;
    logic [DIVW-1:0]  div_q, div_d;
    logic             dir_q, dir_d;
    logic             rx_valid_q, rx_valid_d;
    logic             tick;
    logic [WIDTH-1:0] shifted;
`ifdef BI_SHIFT_PARITY_EN
    logic             par_q, par_d;
    logic             rx_perr_q, rx_perr_d;
    logic             par_tick;
`endif

    assign tick    = (presc_q == div_q);
    assign shifted = dir_q ? {ser_in, shreg_q[WIDTH-1:1]} : {shreg_q[WIDTH-2:0], ser_in};
`ifdef BI_SHIFT_PARITY_EN
    assign par_tick = (bitcnt_q == CW'(WIDTH));
`endif

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        rx_data_d  = rx_data_q;
        bitcnt_d   = bitcnt_q;
        presc_d    = presc_q;
        div_d      = div_q;
        dir_d      = dir_q;
        rx_valid_d = rx_valid_q;
`ifdef BI_SHIFT_PARITY_EN
        par_d      = par_q;
        rx_perr_d  = rx_perr_q;
`endif
        case (state_q)
            IDLE: begin
                // abort outranks a start request in the same cycle
                if (start_valid && !abort) begin
                    shreg_d  = tx_data;
                    dir_d    = dir;
                    div_d    = div;
                    bitcnt_d = '0;
                    presc_d  = '0;
                    state_d  = SHIFT;
`ifdef BI_SHIFT_PARITY_EN
                    par_d    = ^tx_data;
`endif
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d    = IDLE;
                    rx_valid_d = 1'b0;
                end else if (!tick) begin
                    presc_d = presc_q + DIVW'(1);
                end else begin
                    presc_d = '0;
`ifdef BI_SHIFT_PARITY_EN
                    if (par_tick) begin
                        // parity tick: register holds still, ser_in is the far end's parity
                        state_d    = DONE;
                        rx_valid_d = 1'b1;
                        rx_data_d  = shreg_q;
                        rx_perr_d  = ser_in ^ (^shreg_q);
                    end else begin
                        shreg_d  = shifted;
                        bitcnt_d = bitcnt_q + CW'(1);
                    end
`else
                    shreg_d  = shifted;
                    bitcnt_d = bitcnt_q + CW'(1);
                    if (bitcnt_q == CW'(WIDTH - 1)) begin
                        state_d    = DONE;
                        rx_valid_d = 1'b1;
                        rx_data_d  = shifted;
                    end
`endif
                end
            end
            DONE: begin
                if (abort || rx_ready) begin
                    state_d    = IDLE;
                    rx_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            rx_data_q  <= '0;
            bitcnt_q   <= '0;
            presc_q    <= '0;
            div_q      <= '0;
            dir_q      <= 1'b0;
            rx_valid_q <= 1'b0;
`ifdef BI_SHIFT_PARITY_EN
            par_q      <= 1'b0;
            rx_perr_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            rx_data_q  <= rx_data_d;
            bitcnt_q   <= bitcnt_d;
            presc_q    <= presc_d;
            div_q      <= div_d;
            dir_q      <= dir_d;
            rx_valid_q <= rx_valid_d;
`ifdef BI_SHIFT_PARITY_EN
            par_q      <= par_d;
            rx_perr_q  <= rx_perr_d;
`endif
        end
    end

    always_comb begin
        ser_out = 1'b0;
        if (state_q == SHIFT) begin
`ifdef BI_SHIFT_PARITY_EN
            ser_out = par_tick ? par_q : (dir_q ? shreg_q[0] : shreg_q[WIDTH-1]);
`else
            ser_out = dir_q ? shreg_q[0] : shreg_q[WIDTH-1];
`endif
        end
    end

    assign shift_en    = (state_q == SHIFT) && tick && !abort;
    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
`ifdef BI_SHIFT_PARITY_EN
    assign rx_perr     = rx_perr_q;
`else
    assign rx_perr     = 1'b0;
`endif

endmodule

// File: tb/tb_bi_shift_ctrl.sv
// Randomized self-checking bench for bi_shift_ctrl against a bit-order/latency reference model.
module tb_bi_shift_ctrl;
    localparam int W    = 4;
    localparam int DIVW = 8;
`ifdef BI_SHIFT_PARITY_EN
    localparam int PAR  = 1;
`else
    localparam int PAR  = 0;
`endif
    localparam int NT   = W + PAR;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start_valid = 1'b0;
    logic            start_ready;
    logic [W-1:0]    tx_data = '0;
    logic            dir = 1'b0;
    logic [DIVW-1:0] div = '0;
    logic            abort = 1'b0;
    logic            ser_in = 1'b0;
    logic            ser_out;
    logic            shift_en;
    logic            busy;
    logic [W-1:0]    rx_data;
    logic            rx_valid;
    logic            rx_ready = 1'b0;
    logic            rx_perr;

    int n_tests = 0;
    int n_fail  = 0;

    bi_shift_ctrl #(.WIDTH(W), .DIVW(DIVW)) dut (
        .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
        .tx_data(tx_data), .dir(dir), .div(div), .abort(abort), .ser_in(ser_in),
        .ser_out(ser_out), .shift_en(shift_en), .busy(busy), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_perr(rx_perr)
    );

    always #5 clk = ~clk;

    // Received word: first bit in lands at lsb when shifting right, at msb when shifting left.
    function automatic logic [W-1:0] model_rx(input logic [W-1:0] bits, input logic d);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) r[d ? i : W-1-i] = bits[i];
        return r;
    endfunction

    // Transmitted sequence: lsb first when shifting right, msb first when left, then parity.
    function automatic logic [NT-1:0] model_out(input logic [W-1:0] tx, input logic d);
        logic [NT-1:0] s;
        s = '0;
        for (int i = 0; i < W; i++) s[i] = d ? tx[i] : tx[W-1-i];
        if (PAR == 1) s[NT-1] = ^tx;
        return s;
    endfunction

    // mode: 0 random ser_in, 1 loopback, 2 constant one. Returns at the negedge where rx_valid
    // is seen, or after stop_after ticks when stop_after > 0.
    task automatic xfer(input logic [W-1:0] tx, input logic d, input logic [DIVW-1:0] dv,
                        input int mode, input bit bad_par, input int stop_after,
                        output logic [W-1:0] sent, output logic sent_par, output int lat,
                        output int tick_err, output logic [NT-1:0] oseq);
        int  nt;
        logic b;
        sent = '0; sent_par = 1'b0; lat = -1; tick_err = 0; oseq = '0; nt = 0;
        @(negedge clk);
        for (int g = 0; g < 50 && !start_ready; g++) @(negedge clk);
        start_valid = 1'b1; tx_data = tx; dir = d; div = dv;
        @(negedge clk);
        start_valid = 1'b0; tx_data = W'($urandom); dir = 1'($urandom); div = DIVW'($urandom);
        for (int k = 0; k < 4000; k++) begin
            if (stop_after > 0 && nt == stop_after) return;
            if (rx_valid) begin lat = k; break; end
            if (shift_en) begin
                if (k % (int'(dv) + 1) != int'(dv)) tick_err++;
                if (nt < NT) oseq[nt] = ser_out;
                case (mode)
                    1:       b = ser_out;
                    2:       b = 1'b1;
                    default: b = 1'($urandom);
                endcase
                if (nt == W && bad_par) b = ~ser_out;
                ser_in = b;
                if (nt < W) sent[nt] = b; else sent_par = b;
                nt++;
            end else begin
                ser_in = 1'($urandom);
            end
            @(negedge clk);
        end
        if (nt != NT) tick_err++;
    endtask

    task automatic consume();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if ({ser_out, shift_en, busy, rx_valid, rx_perr, start_ready} !== 6'b000001 || rx_data !== '0) begin
            n_fail++;
            $display("FAIL reset_state: outs=%b rx_data=%h required outs=000001 rx_data=0",
                     {ser_out, shift_en, busy, rx_valid, rx_perr, start_ready}, rx_data);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_loopback(input logic [W-1:0] tx, input logic d, input logic [DIVW-1:0] dv);
        logic [W-1:0] sent; logic sp; int lat, terr; logic [NT-1:0] oseq;
        xfer(tx, d, dv, 1, 1'b0, 0, sent, sp, lat, terr, oseq);
        n_tests++;
        if (oseq !== model_out(tx, d)) begin
            n_fail++; $display("FAIL loop_ser_out: got %b required %b", oseq, model_out(tx, d));
        end
        n_tests++;
        if (terr != 0) begin
            n_fail++; $display("FAIL loop_tick_timing: errors %0d required 0", terr);
        end
        n_tests++;
        if (lat != (int'(dv) + 1) * NT) begin
            n_fail++; $display("FAIL loop_latency: got %0d required %0d", lat, (int'(dv) + 1) * NT);
        end
        n_tests++;
        if (rx_data !== tx || rx_perr !== 1'b0) begin
            n_fail++; $display("FAIL loop_rx: got %h perr %b required %h perr 0", rx_data, rx_perr, tx);
        end
        consume();
    endtask

    task automatic test_random(input int iters);
        logic [W-1:0] tx, sent, exp; logic d, sp, ep; logic [DIVW-1:0] dv;
        int lat, terr; logic [NT-1:0] oseq;
        for (int it = 0; it < iters; it++) begin
            tx = W'($urandom); d = 1'($urandom);
            dv = (it == 0) ? DIVW'((1 << DIVW) - 1) : DIVW'($urandom_range(0, 3));
            xfer(tx, d, dv, 0, 1'b0, 0, sent, sp, lat, terr, oseq);
            exp = model_rx(sent, d);
            ep  = (PAR == 1) ? (sp ^ (^exp)) : 1'b0;
            n_tests++;
            if (rx_data !== exp || rx_perr !== ep || lat != (int'(dv) + 1) * NT ||
                terr != 0 || oseq !== model_out(tx, d)) begin
                n_fail++;
                $display("FAIL random_xfer[%0d]: rx %h perr %b lat %0d terr %0d seq %b required rx %h perr %b lat %0d terr 0 seq %b",
                         it, rx_data, rx_perr, lat, terr, oseq, exp, ep, (int'(dv) + 1) * NT, model_out(tx, d));
            end
            consume();
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] sent; logic sp; int lat, terr; logic [NT-1:0] oseq;
        xfer(W'(4'b0110), 1'b1, '0, 1, 1'b0, 2, sent, sp, lat, terr, oseq);
        reset = 1'b0;
        #1;
        n_tests++;
        if ({ser_out, shift_en, busy, rx_valid, rx_perr, start_ready} !== 6'b000001 || rx_data !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: outs=%b rx_data=%h required outs=000001 rx_data=0",
                     {ser_out, shift_en, busy, rx_valid, rx_perr, start_ready}, rx_data);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if (start_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: start_ready %b busy %b required 1 0", start_ready, busy);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] sent; logic sp; int lat, terr; logic [NT-1:0] oseq;
        xfer('0, 1'b0, '0, 2, 1'b0, 0, sent, sp, lat, terr, oseq);
        start_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            n_tests++;
            if (rx_valid !== 1'b1 || rx_data !== '1 || start_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: valid %b data %h ready %b busy %b required 1 %h 0 1",
                         c, rx_valid, rx_data, start_ready, busy, {W{1'b1}});
            end
            @(negedge clk);
        end
        rx_ready = 1'b1;
        @(negedge clk);
        start_valid = 1'b0; rx_ready = 1'b0;
        n_tests++;
        if (rx_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_release: valid %b ready %b busy %b required 0 1 0", rx_valid, start_ready, busy);
        end
    endtask

    task automatic test_abort();
        logic [W-1:0] sent; logic sp; int lat, terr; logic [NT-1:0] oseq; logic [W-1:0] prev;
        logic seen;
        test_loopback(W'(4'b1001), 1'b1, '0);
        prev = W'(4'b1001);
        xfer(W'(4'b0110), 1'b0, '0, 1, 1'b0, 2, sent, sp, lat, terr, oseq);
        abort = 1'b1;
        #1;
        n_tests++;
        if (shift_en !== 1'b0) begin
            n_fail++; $display("FAIL abort_shift_en: got %b required 0", shift_en);
        end
        @(negedge clk);
        abort = 1'b0;
        n_tests++;
        if (start_ready !== 1'b1 || busy !== 1'b0 || rx_valid !== 1'b0 || rx_data !== prev) begin
            n_fail++;
            $display("FAIL abort_idle: ready %b busy %b valid %b data %h required 1 0 0 %h",
                     start_ready, busy, rx_valid, rx_data, prev);
        end
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (rx_valid) seen = 1'b1;
            @(negedge clk);
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL abort_no_valid: rx_valid pulse seen, required none");
        end
        start_valid = 1'b1; abort = 1'b1;
        @(negedge clk);
        start_valid = 1'b0; abort = 1'b0;
        n_tests++;
        if (start_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_idle_priority: ready %b busy %b required 1 0", start_ready, busy);
        end
        test_loopback(W'(4'b0111), 1'b0, DIVW'(1));
    endtask

    task automatic test_parity();
        logic [W-1:0] sent; logic sp; int lat, terr; logic [NT-1:0] oseq;
        xfer(W'(4'b1011), 1'b1, '0, 1, 1'b0, 0, sent, sp, lat, terr, oseq);
        n_tests++;
        if (oseq[NT-1] !== 1'b1 || rx_perr !== 1'b0 || rx_data !== W'(4'b1011)) begin
            n_fail++;
            $display("FAIL parity_good: par %b perr %b data %h required 1 0 b", oseq[NT-1], rx_perr, rx_data);
        end
        consume();
        xfer(W'(4'b1011), 1'b1, '0, 1, 1'b1, 0, sent, sp, lat, terr, oseq);
        n_tests++;
        if (rx_perr !== 1'b1 || rx_data !== W'(4'b1011)) begin
            n_fail++; $display("FAIL parity_bad: perr %b data %h required 1 b", rx_perr, rx_data);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_loopback(W'(4'b1011), 1'b1, '0);
        test_loopback(W'(4'b1011), 1'b0, DIVW'(2));
        test_reset_mid();
        test_backpressure();
        test_abort();
        test_random(16);
`ifdef BI_SHIFT_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bi_shift_ctrl.md
Name: bi_shift_ctrl

Overview:
Sequencer for a WIDTH-bit bidirectional serial shift path. It accepts a parallel word and a direction through a valid/ready handshake, then shifts the word out one bit per prescaled tick. At the same time it captures ser_in into the vacated end of the register. After WIDTH ticks it presents the captured word on a valid/ready output. The block sits between a parallel host interface and a serial link or chain of shift stages.

Parameters:
WIDTH, 4, data word width in bits (>=2)
DIVW, 8, width of the prescaler divide input

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start_valid  input  1  host requests a transfer
start_ready  output  1  block can accept a transfer (IDLE only)
tx_data  input  WIDTH  word to shift out, sampled at accept
dir  input  1  1 = shift right (out of lsb, in at msb); 0 = shift left (out of msb, in at lsb); sampled at accept
div  input  DIVW  tick period minus one, sampled at accept
abort  input  1  synchronous abort; returns to IDLE
ser_in  input  1  serial data in, sampled on tick
ser_out  output  1  serial data out
shift_en  output  1  one-cycle strobe, high in the cycle a shift tick occurs
busy  output  1  high in SHIFT and DONE
rx_data  output  WIDTH  captured word, valid while rx_valid
rx_valid  output  1  captured word available
rx_ready  input  1  consumer accepts rx_data
rx_perr  output  1  parity error flag, qualified by rx_valid

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; shift register, bit counter, prescaler, dir_q, div_q all 0.
  - Outputs: ser_out=0, shift_en=0, busy=0, rx_valid=0, rx_data=0, rx_perr=0, start_ready=1.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start_ready=1, ser_out=0.
  - Accept occurs on start_valid&&start_ready at a rising edge: shreg<=tx_data, dir_q<=dir, div_q<=div, bitcnt<=0, presc<=0, next state SHIFT.
- SHIFT:
  - ser_out is combinational: shreg[0] if dir_q, else shreg[WIDTH-1].
  - Tick condition is presc==div_q. On a tick: presc<=0. Otherwise presc<=presc+1.
  - shift_en = tick && state==SHIFT.
  - On a tick with dir_q=1: shreg<={ser_in, shreg[WIDTH-1:1]}. With dir_q=0: shreg<={shreg[WIDTH-2:0], ser_in}. Then bitcnt<=bitcnt+1.
  - On the tick where bitcnt==WIDTH-1 (last data bit), next state is DONE, and rx_data<=the post-shift shreg value.
- Timing:
  - With div=0 a tick occurs every cycle. rx_valid rises after (div+1)*WIDTH rising edges following the accept edge.
  - div is the maximum value: period 2^DIVW, no overflow, because presc wraps at div_q.
- DONE:
  - rx_valid=1, ser_out=0; rx_data and rx_perr are held stable.
  - On rx_valid&&rx_ready: rx_valid<=0, next state IDLE. The earliest next accept is one cycle later; DONE never accepts.
- Abort:
  - abort=1 in SHIFT or DONE sends the block to IDLE at the next edge. rx_valid<=0, shift_en is suppressed that cycle, and rx_data keeps its last value.
  - abort takes priority over a tick and over rx_ready.
  - abort in IDLE has priority over start_valid: no accept that cycle.
- Loopback: with ser_out tied to ser_in, rx_data==tx_data for both directions.
- Changes to tx_data, dir or div after accept have no effect on the transfer in progress.

Optional Feature:
Macro BI_SHIFT_PARITY_EN.
- Defined:
  - SHIFT runs WIDTH+1 ticks. During the extra tick ser_out = even parity of the latched tx word (XOR of all bits, held in a par_q latched at accept).
  - On that tick ser_in is sampled as the received parity and shreg is not shifted.
  - rx_perr <= (rx_par != XOR of rx_data), updated on DONE entry.
  - The DONE transition moves to the tick where bitcnt==WIDTH.
- Undefined: WIDTH ticks only, and rx_perr is constant 0.

Test Plan:
- Reset: reset=0 mid-SHIFT (after 2 ticks) -> all outputs at reset values immediately; start_ready=1 after release.
- Loopback, WIDTH=4, div=0: tx_data=4'b1011, dir=1 -> shift_en high 4 consecutive cycles; ser_out sequence 1,1,0,1; rx_data=4'b1011, rx_valid after 4 edges.
- Loopback, dir=0, tx_data=4'b1011, div=2 -> ser_out sequence 1,0,1,1, each held 3 cycles; shift_en every 3rd cycle; rx_valid after 12 edges; rx_data=4'b1011.
- Backpressure: ser_in=1 constant, tx_data=0, rx_ready=0 for 5 cycles -> rx_valid held, rx_data=4'b1111 stable, start_ready=0 and start_valid ignored; rx_ready=1 -> IDLE next cycle.
- Abort: abort=1 after 2 ticks with div=0 -> IDLE next edge, no rx_valid pulse, start_ready=1; a new transfer then completes normally.
- BI_SHIFT_PARITY_EN: tx_data=4'b1011, loopback -> 5th tick drives parity 1, rx_perr=0. Force ser_in=0 on the parity tick -> rx_perr=1.
